// File: rtl/imem_load_ctrl.sv
// Boot/reload sequencer: streams a byte image into instruction memory, then
// releases the CPU and polices fetch addresses. Optional macro: IMEM_CHECKSUM_EN.
module imem_load_ctrl #(
    parameter int          MEM_BYTES = 4096,
    parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
    parameter int          AW        = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [AW:0]   len_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_waddr_o,
    output logic [7:0]    mem_wdata_o,
    input  logic [31:0]   fetch_addr_i,
    output logic          cpu_stall_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [1:0]    err_code_o,
    output logic [7:0]    checksum_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH, S_RUN} state_e;

    localparam logic [1:0]  ERR_NONE    = 2'd0;
    localparam logic [1:0]  ERR_BAD_LEN = 2'd1;
    localparam logic [1:0]  ERR_ABORT   = 2'd2;
    localparam logic [1:0]  ERR_FETCH   = 2'd3;
    localparam logic [AW:0] LEN_MAX     = (AW+1)'(MEM_BYTES);
    localparam logic [31:0] MEM_TOP     = 32'(MEM_BYTES);

    // Offsets are relative to the base, so the window must be size-aligned.
    if (BASE_ADDR[AW-1:0] != '0) begin : g_base_chk
        $error("BASE_ADDR must be aligned to MEM_BYTES");
    end

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   len_q, len_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic len_ok, fetch_bad;

    assign len_ok    = (len_i != '0) && (len_i <= LEN_MAX);
    assign fetch_bad = (fetch_addr_i >= MEM_TOP) || (fetch_addr_i[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        code_d  = code_q;
        unique case (state_q)
            S_IDLE, S_RUN: begin
                if (start_i) begin
                    if (len_ok) begin
                        len_d   = len_i;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        code_d  = ERR_NONE;
                        state_d = S_LOAD;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_BAD_LEN;
                        state_d = S_IDLE;
                    end
                end else if (state_q == S_RUN && fetch_bad) begin
                    err_d   = 1'b1;
                    code_d  = ERR_FETCH;
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // Abort wins over a same-cycle handshake, so that byte is dropped.
                if (abort_i) begin
                    err_d   = 1'b1;
                    code_d  = ERR_ABORT;
                    state_d = S_IDLE;
                end else if (byte_valid_i) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q[AW-1:0];
                    wdata_d = byte_data_i;
                    cnt_d   = cnt_q + (AW+1)'(1);
                    if (cnt_q == len_q - (AW+1)'(1)) state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (abort_i) begin
                    err_d   = 1'b1;
                    code_d  = ERR_ABORT;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign byte_ready_o = (state_q == S_LOAD);
    assign busy_o       = (state_q == S_LOAD) || (state_q == S_FINISH);
    assign done_o       = (state_q == S_RUN);
    assign cpu_stall_o  = (state_q != S_RUN);
    assign mem_we_o     = we_q;
    assign mem_waddr_o  = waddr_q;
    assign mem_wdata_o  = wdata_q;
    assign err_o        = err_q;
    assign err_code_o   = code_q;

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (start_i && len_ok && (state_q == S_IDLE || state_q == S_RUN)) begin
            sum_q <= '0;
        end else if (we_d) begin
            sum_q <= sum_q + byte_data_i;
        end
    end

    assign checksum_o = sum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: inputs driven and outputs sampled on the
// falling edge, so each sample reflects the state after the preceding rising edge.
module tb_imem_load_ctrl;

    localparam int AW = 12;
`ifdef IMEM_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW:0]   len_i = '0;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_data_i = '0;
    logic          byte_ready_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_waddr_o;
    logic [7:0]    mem_wdata_o;
    logic [31:0]   fetch_addr_i = '0;
    logic          cpu_stall_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [1:0]    err_code_o;
    logic [7:0]    checksum_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] img [8];

    imem_load_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .len_i        (len_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_waddr_o  (mem_waddr_o),
        .mem_wdata_o  (mem_wdata_o),
        .fetch_addr_i (fetch_addr_i),
        .cpu_stall_o  (cpu_stall_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .checksum_o   (checksum_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ck(input logic [7:0] sum);
        return CK_EN ? sum : 8'h00;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_stall"}, cpu_stall_o, 1);
        chk({tag, "_ready"}, byte_ready_o, 0);
        chk({tag, "_we"},    mem_we_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_done"},  done_o, 0);
        chk({tag, "_err"},   err_o, 0);
        chk({tag, "_code"},  err_code_o, 0);
        chk({tag, "_waddr"}, mem_waddr_o, 0);
        chk({tag, "_wdata"}, mem_wdata_o, 0);
        chk({tag, "_csum"},  checksum_o, 0);
    endtask

    // Pulse start for one cycle; returns on the falling edge after acceptance.
    task automatic do_start(input int len);
        start_i = 1'b1;
        len_i   = (AW+1)'(len);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Each byte's write must appear exactly one edge after its handshake.
    task automatic stream(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            byte_valid_i = 1'b1;
            byte_data_i  = img[i];
            @(negedge clk);
            chk("wr_we",   mem_we_o, 1);
            chk("wr_addr", mem_waddr_o, i);
            chk("wr_data", mem_wdata_o, img[i]);
            byte_valid_i = 1'b0;
            if (gaps && i < n - 1) begin
                @(negedge clk);
                chk("bubble_we", mem_we_o, 0);
            end
        end
    endtask

    // Entered in FINISH (final strobe visible); leaves one cycle later in RUN.
    task automatic finish_run(input logic [7:0] exp_sum);
        chk("fin_ready", byte_ready_o, 0);
        chk("fin_busy",  busy_o, 1);
        chk("fin_stall", cpu_stall_o, 1);
        chk("fin_done",  done_o, 0);
        @(negedge clk);
        chk("run_done",  done_o, 1);
        chk("run_stall", cpu_stall_o, 0);
        chk("run_busy",  busy_o, 0);
        chk("run_we",    mem_we_o, 0);
        chk("run_csum",  checksum_o, ck(exp_sum));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_stall", cpu_stall_o, 1);
        chk("idle_ready", byte_ready_o, 0);

        // Back-to-back 8-byte image
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_start(8);
        chk("t1_ready", byte_ready_o, 1);
        chk("t1_busy",  busy_o, 1);
        stream(8, 1'b0);
        finish_run(8'hB6);
        repeat (2) @(negedge clk);
        chk("t1_fetch0_err",   err_o, 0);
        chk("t1_fetch0_stall", cpu_stall_o, 0);

        // Reload from RUN
        img[0] = 8'h01;
        img[1] = 8'h02;
        do_start(2);
        chk("rl_stall", cpu_stall_o, 1);
        chk("rl_done",  done_o, 0);
        chk("rl_ready", byte_ready_o, 1);
        stream(2, 1'b0);
        finish_run(8'h03);

        // Misaligned fetch
        fetch_addr_i = 32'h2;
        @(negedge clk);
        fetch_addr_i = 32'h0;
        chk("mis_err",   err_o, 1);
        chk("mis_code",  err_code_o, 3);
        chk("mis_stall", cpu_stall_o, 1);
        chk("mis_done",  done_o, 0);
        @(negedge clk);
        chk("mis_idle_ready", byte_ready_o, 0);
        chk("mis_idle_err",   err_o, 1);

        // Bubbled 4-byte stream; accepted start clears the fetch error
        img[0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_start(4);
        chk("t2_err",  err_o, 0);
        chk("t2_code", err_code_o, 0);
        stream(4, 1'b1);
        finish_run(8'hAA);

        // Out-of-range fetch
        fetch_addr_i = 32'h1000;
        @(negedge clk);
        fetch_addr_i = 32'h0;
        chk("oor_err",   err_o, 1);
        chk("oor_code",  err_code_o, 3);
        chk("oor_stall", cpu_stall_o, 1);

        // Bad lengths
        do_start(0);
        chk("len0_err",   err_o, 1);
        chk("len0_code",  err_code_o, 1);
        chk("len0_ready", byte_ready_o, 0);
        chk("len0_busy",  busy_o, 0);
        do_start(4097);
        chk("lenbig_err",   err_o, 1);
        chk("lenbig_code",  err_code_o, 1);
        chk("lenbig_ready", byte_ready_o, 0);
        chk("lenbig_stall", cpu_stall_o, 1);

        // Valid start clears error; abort after 3 of 6 bytes
        img[0:2] = '{8'h55, 8'h66, 8'h77};
        do_start(6);
        chk("ab_err_clr", err_o, 0);
        chk("ab_ready",   byte_ready_o, 1);
        stream(3, 1'b0);
        byte_valid_i = 1'b1;
        byte_data_i  = 8'hEE;
        abort_i      = 1'b1;
        @(negedge clk);
        abort_i      = 1'b0;
        byte_valid_i = 1'b0;
        chk("ab_we",    mem_we_o, 0);
        chk("ab_waddr", mem_waddr_o, 2);
        chk("ab_err",   err_o, 1);
        chk("ab_code",  err_code_o, 2);
        chk("ab_stall", cpu_stall_o, 1);
        chk("ab_busy",  busy_o, 0);
        chk("ab_ready", byte_ready_o, 0);
        @(negedge clk);
        chk("ab_we2", mem_we_o, 0);

        // Reset pulsed mid-load
        do_start(6);
        stream(2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
